// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: display scheduler for a 4-digit multiplexed 7-segment driver.
// A numeric channel is converted binary->BCD by an iterative double-dabble
// engine (14 shift cycles per value); a message channel pre-empts the numeric
// readout for HOLD_CYCLES clocks.
// Optional feature macro: SEG_OVERRANGE_DASH_EN
//   defined   : values above 9999 commit as four dashes (code 10)
//   undefined : values above 9999 are clamped to 9999 at load
module seg_display_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int TW          = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        val_valid,
    input  logic [13:0] val_data,
    output logic        val_ready,
    input  logic        msg_valid,
    input  logic [15:0] msg_digits,
    output logic        msg_ready,
    output logic        conv_done,
    output logic [3:0]  in0,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    output logic [3:0]  in3
);

    typedef enum logic {C_IDLE = 1'b0, C_CONV = 1'b1} conv_state_t;

    conv_state_t   state, state_nx;
    logic [13:0]   bin;
    logic [15:0]   bcd;
    logic [3:0]    count;
    logic [15:0]   digits;
    logic [15:0]   msg;
    logic [TW-1:0] timer;
    logic [15:0]   adj;
    logic [15:0]   bcd_nx;
    logic [13:0]   bin_nx;
    logic          val_xfer;
    logic          msg_xfer;
    logic          last_iter;
`ifdef SEG_OVERRANGE_DASH_EN
    logic          over;
`endif

    assign val_ready = (state == C_IDLE);
    assign msg_ready = (timer == '0);
    assign val_xfer  = val_valid & val_ready;
    assign msg_xfer  = msg_valid & msg_ready;
    assign last_iter = (state == C_CONV) && (count == 4'd0);

    // One double-dabble step: add 3 to each nibble >= 5, then shift {bcd,bin} left
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        {bcd_nx, bin_nx} = {adj[14:0], bin, 1'b0};
    end

    // Next-state logic for the conversion FSM
    always_comb begin
        state_nx = state;
        case (state)
            C_IDLE:  if (val_xfer)  state_nx = C_CONV;
            C_CONV:  if (last_iter) state_nx = C_IDLE;
            default: state_nx = C_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= C_IDLE;
        else        state <= state_nx;
    end

    // Conversion datapath: load on transfer, iterate, commit on the last step
    always_ff @(posedge clock) begin
        if (!reset) begin
            bin       <= '0;
            bcd       <= '0;
            count     <= '0;
            digits    <= 16'h0000;
            conv_done <= 1'b0;
`ifdef SEG_OVERRANGE_DASH_EN
            over      <= 1'b0;
`endif
        end else begin
            conv_done <= 1'b0;
            if (val_xfer) begin
`ifdef SEG_OVERRANGE_DASH_EN
                bin  <= val_data;
                over <= (val_data > 14'd9999);
`else
                bin  <= (val_data > 14'd9999) ? 14'd9999 : val_data;
`endif
                bcd   <= '0;
                count <= 4'd13;
            end else if (state == C_CONV) begin
                bin <= bin_nx;
                bcd <= bcd_nx;
                if (last_iter) begin
`ifdef SEG_OVERRANGE_DASH_EN
                    digits <= over ? 16'hAAAA : bcd_nx;
`else
                    digits <= bcd_nx;
`endif
                    conv_done <= 1'b1;
                end else begin
                    count <= count - 4'd1;
                end
            end
        end
    end

    // Message latch and hold timer
    always_ff @(posedge clock) begin
        if (!reset) begin
            msg   <= '0;
            timer <= '0;
        end else if (msg_xfer) begin
            msg   <= msg_digits;
            timer <= TW'(HOLD_CYCLES);
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    // Display mux: held message wins over the numeric readout
    always_comb begin
        if (timer != '0) {in3, in2, in1, in0} = msg;
        else             {in3, in2, in1, in0} = digits;
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed testbench for seg_display_ctrl (HOLD_CYCLES = 8).
module tb_seg_display_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        val_valid = 1'b0;
    logic [13:0] val_data = '0;
    logic        val_ready;
    logic        msg_valid = 1'b0;
    logic [15:0] msg_digits = '0;
    logic        msg_ready;
    logic        conv_done;
    logic [3:0]  in0, in1, in2, in3;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses;

    seg_display_ctrl #(.HOLD_CYCLES(8), .TW(26)) dut (
        .clock(clock), .reset(reset),
        .val_valid(val_valid), .val_data(val_data), .val_ready(val_ready),
        .msg_valid(msg_valid), .msg_digits(msg_digits), .msg_ready(msg_ready),
        .conv_done(conv_done),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3)
    );

    always #5 clock = ~clock;

    // advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {in3, in2, in1, in0};
    endfunction

    // full conversion with latency/throughput checks, no message active
    task automatic do_conv(input string tag, input logic [13:0] v, input logic [15:0] exp);
        int low;
        val_valid = 1'b1;
        val_data  = v;
        tick;
        val_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 13; i++) begin
            if (!val_ready && !conv_done) low++;
            tick;
        end
        if (!val_ready && !conv_done) low++;
        chk({tag, "_busy14"}, 16'(low), 16'd14);
        tick;
        chk({tag, "_done"}, {15'd0, conv_done}, 16'd1);
        chk({tag, "_disp"}, disp(), exp);
        chk({tag, "_ready"}, {15'd0, val_ready}, 16'd1);
    endtask

    initial begin
        // reset
        tick; tick;
        chk("rst_disp", disp(), 16'h0000);
        chk("rst_vrdy", {15'd0, val_ready}, 16'd1);
        chk("rst_mrdy", {15'd0, msg_ready}, 16'd1);
        chk("rst_done", {15'd0, conv_done}, 16'd0);
        reset = 1'b1;
        tick;

        // basic conversion and boundaries
        do_conv("c1234", 14'd1234, 16'h1234);
        tick;
        chk("c1234_pulse1", {15'd0, conv_done}, 16'd0);
        do_conv("c0", 14'd0, 16'h0000);
        do_conv("c9999", 14'd9999, 16'h9999);
`ifdef SEG_OVERRANGE_DASH_EN
        do_conv("c16383", 14'd16383, 16'hAAAA);
`else
        do_conv("c16383", 14'd16383, 16'h9999);
`endif
        do_conv("c10000", 14'd10000, 16'h9999
`ifdef SEG_OVERRANGE_DASH_EN
            ^ 16'h3333
`endif
        );
        do_conv("c42", 14'd42, 16'h0042);

        // message pre-emption
        msg_valid  = 1'b1;
        msg_digits = 16'hAAAA;
        tick;
        msg_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("hold_disp", disp(), 16'hAAAA);
            chk("hold_mrdy", {15'd0, msg_ready}, 16'd0);
            tick;
        end
        chk("hold_disp7", disp(), 16'hAAAA);
        tick;
        chk("hold_revert", disp(), 16'h0042);
        chk("hold_mrdy_up", {15'd0, msg_ready}, 16'd1);

        // conversion completing during a hold
        val_valid = 1'b1;
        val_data  = 14'd777;
        tick;                       // k
        val_valid = 1'b0;
        repeat (9) tick;            // k+9
        msg_valid  = 1'b1;
        msg_digits = 16'h5B3C;
        tick;                       // k+10
        msg_valid = 1'b0;
        chk("ch_msg", disp(), 16'h5B3C);
        repeat (4) tick;            // k+14
        chk("ch_done", {15'd0, conv_done}, 16'd1);
        chk("ch_still_msg", disp(), 16'h5B3C);
        repeat (3) tick;            // k+17
        chk("ch_msg17", disp(), 16'h5B3C);
        chk("ch_mrdy17", {15'd0, msg_ready}, 16'd0);
        tick;                       // k+18
        chk("ch_revert", disp(), 16'h0777);
        chk("ch_mrdy18", {15'd0, msg_ready}, 16'd1);

        // simultaneous requests and back-pressure
        val_valid  = 1'b1;
        val_data   = 14'd55;
        msg_valid  = 1'b1;
        msg_digits = 16'hFEDC;
        tick;                       // k
        msg_valid = 1'b0;
        val_data  = 14'd321;        // held high through C_CONV
        chk("sim_vrdy", {15'd0, val_ready}, 16'd0);
        chk("sim_mrdy", {15'd0, msg_ready}, 16'd0);
        chk("sim_disp", disp(), 16'hFEDC);
        repeat (14) tick;           // k+14
        chk("sim_done", {15'd0, conv_done}, 16'd1);
        chk("sim_disp55", disp(), 16'h0055);
        chk("sim_vrdy14", {15'd0, val_ready}, 16'd1);
        tick;                       // k+15: second value accepted
        val_valid = 1'b0;
        chk("bp_accept", {15'd0, val_ready}, 16'd0);
        repeat (13) tick;
        chk("bp_notyet", {15'd0, conv_done}, 16'd0);
        tick;
        chk("bp_done", {15'd0, conv_done}, 16'd1);
        chk("bp_disp", disp(), 16'h0321);

        // reset at conversion cycle 7
        val_valid = 1'b1;
        val_data  = 14'd888;
        tick;
        val_valid = 1'b0;
        repeat (7) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("rc_disp", disp(), 16'h0000);
        chk("rc_vrdy", {15'd0, val_ready}, 16'd1);
        chk("rc_done", {15'd0, conv_done}, 16'd0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (conv_done !== 1'b0) pulses++;
        end
        chk("rc_nopulse", 16'(pulses), 16'd0);
        chk("rc_disp_after", disp(), 16'h0000);

        // reset during a hold
        msg_valid  = 1'b1;
        msg_digits = 16'h1B2C;
        tick;
        msg_valid = 1'b0;
        tick;
        chk("rh_msg", disp(), 16'h1B2C);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("rh_disp", disp(), 16'h0000);
        chk("rh_mrdy", {15'd0, msg_ready}, 16'd1);

        do_conv("post_rst", 14'd2468, 16'h2468);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Display scheduler feeding the four 4-bit digit inputs (`in0`..`in3`) of the multiplexed seven-segment driver. It shares the display between two requesters: a numeric channel carrying a binary value, such as the PWM duty count, and a message channel carrying four raw digit codes. Numeric values are converted to BCD by an iterative shift-add-3 (double-dabble) engine. Messages pre-empt the numeric readout for a fixed hold time, after which the latest converted value is shown again.

## Interface
- `HOLD_CYCLES`, 50_000_000 — clock cycles a message stays on the display (1 s at 50 MHz); legal range ≥ 2
- `TW`, 26 — width of the hold timer; must hold `HOLD_CYCLES`
- `clock` in 1 — single clock; all logic on its rising edge
- `reset` in 1 — synchronous, active-low; sampled on the `clock` rising edge
- `val_valid` in 1 — numeric request valid
- `val_data` in 14 — unsigned binary value to display
- `val_ready` out 1 — numeric channel can accept; high only in state C_IDLE
- `msg_valid` in 1 — message request valid
- `msg_digits` in 16 — four digit codes; [3:0]→`in0` … [15:12]→`in3`
- `msg_ready` out 1 — message channel can accept; high when no message is being held
- `conv_done` out 1 — one-cycle pulse when a new numeric value is committed
- `in0`, `in1`, `in2`, `in3` out 4 each — digit codes to the segment driver; `in0` is the ones digit, rightmost display

## Operation
- **Reset** (`reset`=0 at an edge):
  - state = C_IDLE, shift/BCD registers = 0, digit register = 16'h0000
  - hold timer = 0, message register = 0, `conv_done` = 0
  - outputs after reset: `in0`..`in3` = 0, `val_ready` = 1, `msg_ready` = 1
- **Numeric FSM**, two states C_IDLE and C_CONV:
  - C_IDLE: a transfer occurs when `val_valid` & `val_ready` at an edge. The engine loads the binary register with `val_data`, clears the 16-bit BCD register, sets the iteration count to 13, and moves to C_CONV.
  - C_CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, binary} left by one. When the count reaches 0, the result is written to the digit register, `conv_done` pulses, and the FSM returns to C_IDLE. Otherwise the count decrements.
  - `val_valid` is ignored while in C_CONV; the requester holds its data until `val_ready` is high.
- **Message channel**:
  - A transfer occurs when `msg_valid` & `msg_ready`. It latches `msg_digits` and loads the timer with `HOLD_CYCLES`.
  - While the timer ≠ 0: it decrements every cycle, `msg_ready` = 0, and `in0`..`in3` = message register.
  - When the timer is 0: `in0`..`in3` = digit register.
- **Channel independence**:
  - The two channels never block each other.
  - Numeric conversions accepted during a hold update the digit register silently. The newest value appears when the hold expires.
  - Numeric and message transfers in the same cycle are both accepted.
- **Over-range** (`val_data` > 9999): handled per Configuration. In both modes the conversion takes the normal 14 cycles.
- **Codes**: message codes pass through unchecked, including 10 (dash) and 11–15.

## Timing
- **Numeric latency**: transfer at edge k; digit register and `conv_done` update at edge k+14. The display changes in the cycle after k+14, unless a hold is active.
- **Throughput**: one numeric value per 15 cycles. `val_ready` is low for exactly 14 cycles after each transfer.
- **Message timing**:
  - Accept at edge m: message visible from edge m.
  - Timer reaches 0 at edge m+HOLD_CYCLES; display reverts at that same edge.
  - `msg_ready` rises at edge m+HOLD_CYCLES, so the earliest next message is accepted at edge m+HOLD_CYCLES+1.
- **Reset mid-operation**: an active-low `reset` at any edge aborts a conversion and a hold. Everything returns to reset values at that edge, with no `conv_done` pulse.
- **Combinational paths**: none from inputs to outputs. `in0`..`in3`, `val_ready` and `msg_ready` are decoded from registers only.

## Configuration
- **Macro**: `SEG_OVERRANGE_DASH_EN`
- **Defined**: when `val_data` > 9999, the value is still converted for 14 cycles, but the commit writes code 10 to all four digits. The display shows dash-dash-dash-dash.
- **Undefined**: `val_data` > 9999 is clamped to 9999 at load, and the display shows 9999.

## Test plan
- **Basic conversion**: after reset, `val_data`=1234 with `val_valid` for one cycle → `val_ready` low for 14 cycles; `conv_done` at edge +14; `in3..in0` = 1,2,3,4.
- **Boundary values**: 0 → 0,0,0,0; 9999 → 9,9,9,9; 16383 → dashes (macro defined) or 9,9,9,9 (macro undefined).
- **Message pre-emption** (`HOLD_CYCLES`=8): display showing 0042, send message 16'hAAAA → `in0`..`in3` = 10 for 8 cycles; `msg_ready` low throughout; display reverts to 0042.
- **Conversion during hold**: during a hold, convert 777 → display unchanged until the hold expires, then 0777.
- **Simultaneous requests and back-pressure**: numeric and message transfers in the same cycle are both accepted. A second `val_valid` held high during C_CONV is accepted only at the first edge with `val_ready`=1, and its value is displayed.
- **Reset mid-operation**: pull `reset` low at conversion cycle 7 and during a hold → all outputs at reset values; no `conv_done` pulse; the next conversion completes normally.
